// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and width helper for the shift-subtract divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sub_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider_if
// Brief    : Start/operand/result bundle between a requester and the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_sub_divider_if #(
  parameter int P_WIDTH = 4
) ();

  logic                   i_START;
  logic [2*P_WIDTH-1:0]   i_DIVIDEND;
  logic [P_WIDTH-1:0]     i_DIVISOR;
  logic [P_WIDTH-1:0]     o_QUOTIENT;
  logic [P_WIDTH-1:0]     o_REMAINDER;
  logic                   o_BUSY;
  logic                   o_DONE;
  logic                   o_DIV_ZERO;
  logic                   o_OVERFLOW;

  modport master (
    output i_START, i_DIVIDEND, i_DIVISOR,
    input  o_QUOTIENT, o_REMAINDER, o_BUSY, o_DONE, o_DIV_ZERO, o_OVERFLOW
  );

  modport slave (
    input  i_START, i_DIVIDEND, i_DIVISOR,
    output o_QUOTIENT, o_REMAINDER, o_BUSY, o_DONE, o_DIV_ZERO, o_OVERFLOW
  );

endinterface
`default_nettype wire

// File: rtl/divider_result.sv
`default_nettype none
// ============================================================================
// Module   : divider_result
// Brief    : Accumulator/divisor registers and one restoring shift-subtract step.
// Revision : 1.0 - initial release
// ============================================================================
module divider_result
  import div_pkg::*;
#(
  parameter int P_WIDTH = 4
) (
  input  wire logic                   i_CLK,
  input  wire logic                   i_RESET,
  input  wire logic                   i_load,
  input  wire logic                   i_shift,
  input  wire logic [2*P_WIDTH-1:0]   i_dividend,
  input  wire logic [P_WIDTH-1:0]     i_divisor,
  output logic      [P_WIDTH-1:0]     o_step_quot,
  output logic      [P_WIDTH-1:0]     o_step_rem
);

  localparam int c_W = P_WIDTH;

  // The accumulator's extra top bit is always zero between steps (partial
  // remainder < divisor), so it only exists combinationally as the shift-out.
  logic [2*c_W-1:0] r_acc;
  logic [c_W-1:0]   r_divisor;

  logic [2*c_W:0]   w_shifted;
  logic             w_ge;
  logic [c_W-1:0]   w_diff;
  logic [2*c_W-1:0] w_acc_next;

  assign w_shifted  = {r_acc, 1'b0};
  assign w_ge       = w_shifted[2*c_W:c_W] >= {1'b0, r_divisor};
  assign w_diff     = w_shifted[2*c_W-1:c_W] - r_divisor;
  assign w_acc_next = w_ge ? {w_diff, w_shifted[c_W-1:1], 1'b1}
                           : w_shifted[2*c_W-1:0];

  assign o_step_quot = w_acc_next[c_W-1:0];
  assign o_step_rem  = w_acc_next[2*c_W-1:c_W];

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      r_acc     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_acc     <= i_dividend;
      r_divisor <= i_divisor;
    end else if (i_shift) begin
      r_acc     <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider
// Brief    : Sequential restoring unsigned divider, 2W/W -> W quotient and remainder.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int P_WIDTH = 4
) (
  input  wire logic          i_CLK,
  input  wire logic          i_RESET,
  shift_sub_divider_if.slave bus
);

  localparam int                c_W     = P_WIDTH;
  localparam int                c_CNT_W = clog2(P_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(P_WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_count;
  logic [c_W-1:0]     r_quot;
  logic [c_W-1:0]     r_rem;
  logic               r_div_zero;
  logic               r_overflow;

  logic               w_load;
  logic               w_shift;
  logic               w_ld_err;
  logic               w_ld_res;
  logic               w_is_zero;
  logic               w_is_ovf;
  logic [c_W-1:0]     w_step_quot;
  logic [c_W-1:0]     w_step_rem;

  assign w_is_zero = (bus.i_DIVISOR == '0);
  assign w_is_ovf  = (bus.i_DIVIDEND[2*c_W-1:c_W] >= bus.i_DIVISOR);

  divider_result #(
    .P_WIDTH (P_WIDTH)
  ) u_result (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_dividend  (bus.i_DIVIDEND),
    .i_divisor   (bus.i_DIVISOR),
    .o_step_quot (w_step_quot),
    .o_step_rem  (w_step_rem)
  );

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_ld_err     = 1'b0;
    w_ld_res     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_START) begin
          w_load = 1'b1;
          if (w_is_zero || w_is_ovf) begin
            w_ld_err     = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_shift = 1'b1;
        if (r_count == c_LAST) begin
          w_ld_res     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else if (w_shift) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A zero divisor also satisfies the overflow compare; it reports only as div-by-zero.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_div_zero <= w_is_zero;
      r_overflow <= w_is_ovf && !w_is_zero;
      if (w_ld_err) begin
        r_quot <= '0;
        r_rem  <= '0;
      end
    end else if (w_ld_res) begin
      r_quot <= w_step_quot;
      r_rem  <= w_step_rem;
    end
  end

  assign bus.o_QUOTIENT  = r_quot;
  assign bus.o_REMAINDER = r_rem;
  assign bus.o_BUSY      = (r_state == S_CALC);
  assign bus.o_DONE      = (r_state == S_DONE);
  assign bus.o_DIV_ZERO  = r_div_zero;
  assign bus.o_OVERFLOW  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sub_divider
// Brief    : Self-checking bench for shift_sub_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sub_divider;

  localparam int W  = 4;
  localparam int W2 = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_sub_divider_if #(.P_WIDTH(W)) bus ();

  shift_sub_divider #(.P_WIDTH(W)) dut (
    .i_CLK   (clk),
    .i_RESET (rst_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division plus the two error rules.
  task automatic model(input int dd, input int dv,
                       output int q, output int r, output int dz, output int ov);
    dz = (dv == 0) ? 1 : 0;
    ov = (dz == 0 && (dd / (1 << W)) >= dv) ? 1 : 0;
    if (dz != 0 || ov != 0) begin
      q = 0;
      r = 0;
    end else begin
      q = dd / dv;
      r = dd % dv;
    end
  endtask

  task automatic run_op(input int dd, input int dv);
    int eq, er, ez, eo, lat, nbusy, elat;
    model(dd, dv, eq, er, ez, eo);
    elat = (ez != 0 || eo != 0) ? 1 : W + 1;
    @(negedge clk);
    bus.i_START    = 1'b1;
    bus.i_DIVIDEND = W2'(dd);
    bus.i_DIVISOR  = W'(dv);
    @(negedge clk);
    bus.i_START    = 1'b0;
    bus.i_DIVIDEND = W2'($urandom);
    bus.i_DIVISOR  = W'($urandom);
    lat   = 1;
    nbusy = 0;
    while (!bus.o_DONE && lat < 20) begin
      if (bus.o_BUSY) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("busy_cycles", nbusy, elat - 1);
    check("quotient", 32'(bus.o_QUOTIENT), eq);
    check("remainder", 32'(bus.o_REMAINDER), er);
    check("div_zero", 32'(bus.o_DIV_ZERO), ez);
    check("overflow", 32'(bus.o_OVERFLOW), eo);
    @(negedge clk);
    check("done_pulse", 32'(bus.o_DONE), 0);
    check("hold_q", 32'(bus.o_QUOTIENT), eq);
  endtask

  initial begin
    int t[$];
    int ndone, lat, stride, off, idx;

    bus.i_START    = 1'b0;
    bus.i_DIVIDEND = '0;
    bus.i_DIVISOR  = '0;
    repeat (3) @(negedge clk);
    check("rst_q", 32'(bus.o_QUOTIENT), 0);
    check("rst_r", 32'(bus.o_REMAINDER), 0);
    check("rst_busy", 32'(bus.o_BUSY), 0);
    check("rst_done", 32'(bus.o_DONE), 0);
    check("rst_dz", 32'(bus.o_DIV_ZERO), 0);
    check("rst_ov", 32'(bus.o_OVERFLOW), 0);
    rst_n = 1'b1;

    run_op(100, 7);
    run_op(239, 15);
    run_op(0, 5);
    run_op(77, 0);
    run_op(200, 3);

    // Starts during CALC and DONE must be ignored.
    @(negedge clk);
    bus.i_START = 1'b1; bus.i_DIVIDEND = 8'd100; bus.i_DIVISOR = 4'd7;
    @(negedge clk);
    bus.i_START = 1'b0;
    @(negedge clk);
    bus.i_START = 1'b1; bus.i_DIVIDEND = 8'd50; bus.i_DIVISOR = 4'd5;
    @(negedge clk);
    bus.i_START = 1'b0;
    lat = 0;
    while (!bus.o_DONE && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done_seen", 32'(bus.o_DONE), 1);
    bus.i_START = 1'b1;
    @(negedge clk);
    bus.i_START = 1'b0;
    check("ign_busy", 32'(bus.o_BUSY), 0);
    check("ign_q", 32'(bus.o_QUOTIENT), 14);
    check("ign_r", 32'(bus.o_REMAINDER), 2);
    @(negedge clk);
    check("ign_idle", 32'(bus.o_BUSY), 0);

    // Start held high: one operation every W+2 cycles.
    @(negedge clk);
    bus.i_START = 1'b1; bus.i_DIVIDEND = 8'd100; bus.i_DIVISOR = 4'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_DONE) begin
        t.push_back(i);
        check("held_q", 32'(bus.o_QUOTIENT), 14);
      end
    end
    bus.i_START = 1'b0;
    check("held_count", 32'(t.size()), 3);
    if (t.size() >= 3) begin
      check("held_period1", t[1] - t[0], W + 2);
      check("held_period2", t[2] - t[1], W + 2);
    end
    repeat (W + 3) @(negedge clk);

    // Reset after two iterations aborts without a done pulse.
    bus.i_START = 1'b1; bus.i_DIVIDEND = 8'd100; bus.i_DIVISOR = 4'd7;
    @(negedge clk);
    bus.i_START = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_q", 32'(bus.o_QUOTIENT), 0);
    check("abort_r", 32'(bus.o_REMAINDER), 0);
    check("abort_busy", 32'(bus.o_BUSY), 0);
    check("abort_done", 32'(bus.o_DONE), 0);
    check("abort_dz", 32'(bus.o_DIV_ZERO), 0);
    check("abort_ov", 32'(bus.o_OVERFLOW), 0);
    ndone = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.o_DONE) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(45, 6);

    // Every dividend/divisor pair, visited in a random permutation.
    stride = int'(($urandom | 32'd1) & 32'hFFF);
    off    = int'($urandom & 32'hFFF);
    for (int k = 0; k < 4096; k++) begin
      idx = (k * stride + off) & 12'hFFF;
      run_op(idx >> 4, idx & 15);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
